// File: rtl/serial_adder_if.sv
// Start/operand/result bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder (sum = a + b + cin), LSB first through one full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow flag (bus.ovf).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             s_bit;
    logic             c_bit;
    logic             last_bit;

    // The single full-adder cell shared by every bit position.
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_bit    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state)
            IDLE: if (bus.start) state_nx = RUN;
            RUN: begin
                bus.busy = 1'b1;
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the final bit, carry holds the carry into the MSB and c_bit the carry out of it.
    always_ff @(posedge clk) begin
        if (rst)                          ovf_q <= 1'b0;
        else if (state == RUN && last_bit) ovf_q <= carry ^ c_bit;
    end

    assign bus.ovf = ovf_q;
`endif

    // NOTE: the operand shift registers are reset along with the result even though
    // they are always reloaded before use, keeping every flop free of X after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    a_sh  <= bus.a;
                    b_sh  <= bus.b;
                    carry <= bus.cin;
                    cnt   <= '0;
                    sum_q <= '0;
                end
                RUN: begin
                    sum_q <= {s_bit, sum_q[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_bit;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) cout_q <= c_bit;
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands against
// an integer-arithmetic reference model.
module tb_serial_adder;
    localparam int W  = 8;
    localparam int P  = W + 2;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [W-1:0] bb_a   [0:NB*P-1];
    logic [W-1:0] bb_b   [0:NB*P-1];
    logic         bb_cin [0:NB*P-1];

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned and signed integer addition.
    function automatic void ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic rc, output logic [W-1:0] rs,
                                    output logic rco, output logic rov);
        int ua = int'(ra);
        int ub = int'(rb);
        int tot = ua + ub + int'(rc);
        int sa = ra[W-1] ? ua - (1 << W) : ua;
        int sb = rb[W-1] ? ub - (1 << W) : ub;
        int st = sa + sb + int'(rc);
        rs  = W'(tot % (1 << W));
        rco = (tot >= (1 << W));
        rov = (st > (1 << (W - 1)) - 1) || (st < -(1 << (W - 1)));
    endfunction

    // Starts one operation from IDLE (called at a negedge) and ends at the negedge
    // after the DUT has returned to IDLE.
    task automatic do_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic icin);
        logic [W-1:0] es, rs;
        logic         ec, eo, rc, ro;
        int           lat, pulses;
        ref_add(ia, ib, icin, es, ec, eo);
        bus.start = 1'b1; bus.a = ia; bus.b = ib; bus.cin = icin;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = -1; pulses = 0; rs = '0; rc = 1'b0; ro = 1'b0;
        for (int k = 0; k <= W + 1; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.done) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; rs = bus.sum; rc = bus.cout;
`ifdef SERIAL_ADDER_OVF_EN
                    ro = bus.ovf;
`endif
                end
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        chk({tag, "_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_sum"}, 32'(rs), 32'(es));
        chk({tag, "_cout"}, 32'(rc), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 32'(ro), 32'(eo));
`endif
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] es;
        logic         ec, eo;
        int           pulses, lat;

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif

        do_op("add_25_13", 8'h25, 8'h13, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_sum", 32'(bus.sum), 32'h38);
            chk("hold_cout", 32'(bus.cout), 32'd0);
            chk("hold_done", 32'(bus.done), 32'd0);
            @(negedge clk);
        end

        do_op("ff_01", 8'hFF, 8'h01, 1'b0);
        do_op("ff_00_c", 8'hFF, 8'h00, 1'b1);
        do_op("00_00_c", 8'h00, 8'h00, 1'b1);

        // Starts during RUN and during DONE must both be ignored.
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0; lat = -1;
        for (int k = 0; k <= W + 5; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.done) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (k == 3 || k == W) begin
                bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("ign_pulses", 32'(pulses), 32'd1);
        chk("ign_latency", 32'(lat), 32'(W));
        chk("ign_sum", 32'(bus.sum), 32'h30);
        chk("ign_cout", 32'(bus.cout), 32'd0);
        chk("ign_idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of RUN aborts the operation.
        bus.start = 1'b1; bus.a = 8'hF0; bus.b = 8'h0F; bus.cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        pulses = 0;
        for (int k = 0; k < W + 2; k++) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
        chk("abort_nodone", 32'(pulses), 32'd0);
        do_op("after_abort", 8'h01, 8'h01, 1'b0);

        // Start held high: acceptances only every W+2 cycles, operands as sampled then.
        pulses = 0;
        for (int t = 0; t < NB * P; t++) begin
            bus.start = 1'b1;
            bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
            bb_a[t] = bus.a; bb_b[t] = bus.b; bb_cin[t] = bus.cin;
            @(posedge clk);
            @(negedge clk);
            if (t >= W && (t - W) % P == 0) begin
                ref_add(bb_a[t-W], bb_b[t-W], bb_cin[t-W], es, ec, eo);
                chk("b2b_done", 32'(bus.done), 32'd1);
                chk("b2b_sum", 32'(bus.sum), 32'(es));
                chk("b2b_cout", 32'(bus.cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
                chk("b2b_ovf", 32'(bus.ovf), 32'(eo));
`endif
            end else begin
                chk("b2b_nodone", 32'(bus.done), 32'd0);
            end
            if (bus.done) pulses++;
        end
        bus.start = 1'b0;
        chk("b2b_count", 32'(pulses), 32'(NB));
        @(negedge clk);

`ifdef SERIAL_ADDER_OVF_EN
        do_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0);
        chk("ovf_7f_01_flag", 32'(bus.ovf), 32'd1);
        do_op("ovf_80_80", 8'h80, 8'h80, 1'b0);
        chk("ovf_80_80_flag", 32'(bus.ovf), 32'd1);
        do_op("ovf_ff_01", 8'hFF, 8'h01, 1'b0);
        chk("ovf_ff_01_flag", 32'(bus.ovf), 32'd0);
`endif

        for (int i = 0; i < 12; i++) begin
            do_op("rand", W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
